// File: rtl/sub_regbank_pipe.sv
// VME-style register bank: N_RW read/write words and N_RO read-only words, with
// optional write-input pipelining and a read-only acknowledge handshake with timeout.
module sub_regbank_pipe #(
  parameter int                     DATA_W  = 16,
  parameter int                     ADDR_W  = 3,
  parameter int                     N_RW    = 2,
  parameter int                     N_RO    = 2,
  parameter logic [N_RW*DATA_W-1:0] RW_RST  = '0,
  parameter int                     WR_PIPE = 1,
  parameter int                     TIMEOUT = 15
) (
  input  logic                   Clk,
  input  logic                   RstN,
  input  logic [ADDR_W:1]        VMEAddr,
  output logic [DATA_W-1:0]      VMERdData,
  input  logic [DATA_W-1:0]      VMEWrData,
  input  logic                   VMERdMem,
  input  logic                   VMEWrMem,
  output logic                   VMERdDone,
  output logic                   VMEWrDone,
  output logic [N_RW*DATA_W-1:0] Rw_o,
  output logic [N_RW-1:0]        RwWStb_o,
  input  logic [N_RO*DATA_W-1:0] Ro_i,
  output logic [N_RO-1:0]        RoRStb_o,
  input  logic [N_RO-1:0]        RoAck_i,
  output logic                   RdTimeout_o,
  output logic [1:0]             rd_state_o
);

  // Bus handshake: VMERdMem/VMEWrMem are one-cycle request pulses; every accepted
  // request is answered by exactly one one-cycle VMERdDone/VMEWrDone pulse. At most one
  // read is outstanding; a VMERdMem arriving while the read FSM is busy is dropped.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RO_W  = (N_RO > 1) ? $clog2(N_RO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic                   wr_req_q, wr_req_d, wr_req;
  logic [ADDR_W-1:0]      wr_idx_q, wr_idx_d, wr_idx;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d, wr_data;
  logic [N_RW*DATA_W-1:0] rw_q, rw_d;
  logic [N_RW-1:0]        wstb_q, wstb_d;

  logic [1:0]             rd_state_q, rd_state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RO_W-1:0]        sel_q, sel_d;
  logic [DATA_W-1:0]      cap_data_q, cap_data_d;
  logic                   cap_to_q, cap_to_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic                   rd_done_q, rd_done_d;
  logic [N_RO-1:0]        rostb_q, rostb_d;
  logic                   to_q, to_d;

  int                     rd_idx;
  logic [DATA_W-1:0]      rw_rd_val, ro_rd_val, ro_sel_val;
  logic                   ro_rd_hit, ack_sel;
  logic [RO_W-1:0]        ro_rd_sel;

  // Write path: the decode sees either the registered or the live request.
  always_comb begin
    wr_req_d  = VMEWrMem;
    wr_idx_d  = VMEAddr;
    wr_data_d = VMEWrData;
    if (WR_PIPE != 0) begin
      wr_req  = wr_req_q;
      wr_idx  = wr_idx_q;
      wr_data = wr_data_q;
    end else begin
      wr_req  = VMEWrMem;
      wr_idx  = VMEAddr;
      wr_data = VMEWrData;
    end
    rw_d   = rw_q;
    wstb_d = '0;
    for (int k = 0; k < N_RW; k++) begin
      if (wr_req && int'(wr_idx) == k) begin
        rw_d[k*DATA_W +: DATA_W] = wr_data;
        wstb_d[k]                = 1'b1;
      end
    end
  end

  // Read decode: unmapped and read-only indices leave rw_rd_val at zero.
  always_comb begin
    rd_idx     = int'(VMEAddr);
    rw_rd_val  = '0;
    ro_rd_val  = '0;
    ro_rd_hit  = 1'b0;
    ro_rd_sel  = '0;
    ack_sel    = 1'b0;
    ro_sel_val = '0;
    for (int k = 0; k < N_RW; k++) begin
      if (rd_idx == k) rw_rd_val = rw_q[k*DATA_W +: DATA_W];
    end
    for (int k = 0; k < N_RO; k++) begin
      if (rd_idx == N_RW + k) begin
        ro_rd_hit = 1'b1;
        ro_rd_val = Ro_i[k*DATA_W +: DATA_W];
        ro_rd_sel = RO_W'(k);
      end
      if (sel_q == RO_W'(k)) begin
        ack_sel    = RoAck_i[k];
        ro_sel_val = Ro_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    cap_data_d = cap_data_q;
    cap_to_d   = cap_to_q;
    rd_data_d  = rd_data_q;
    rd_done_d  = 1'b0;
    rostb_d    = '0;
    to_d       = 1'b0;
    case (rd_state_q)
      ST_IDLE: begin
        if (VMERdMem) begin
          if (ro_rd_hit && TIMEOUT > 0) begin
            sel_d      = ro_rd_sel;
            cnt_d      = '0;
            rd_state_d = ST_WAIT;
            for (int k = 0; k < N_RO; k++) rostb_d[k] = (ro_rd_sel == RO_W'(k));
          end else begin
            rd_done_d = 1'b1;
            rd_data_d = ro_rd_hit ? ro_rd_val : rw_rd_val;
          end
        end
      end
      ST_WAIT: begin
        // An ack on the final count still wins over the timeout.
        if (ack_sel) begin
          cap_data_d = ro_sel_val;
          cap_to_d   = 1'b0;
          rd_state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          cap_data_d = '1;
          cap_to_d   = 1'b1;
          rd_state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        rd_done_d  = 1'b1;
        rd_data_d  = cap_data_q;
        to_d       = cap_to_q;
        rd_state_d = ST_IDLE;
      end
      default: rd_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wr_req_q   <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      rw_q       <= RW_RST;
      wstb_q     <= '0;
      rd_state_q <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      cap_data_q <= '0;
      cap_to_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_done_q  <= 1'b0;
      rostb_q    <= '0;
      to_q       <= 1'b0;
    end else begin
      wr_req_q   <= wr_req_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      rw_q       <= rw_d;
      wstb_q     <= wstb_d;
      rd_state_q <= rd_state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      cap_data_q <= cap_data_d;
      cap_to_q   <= cap_to_d;
      rd_data_q  <= rd_data_d;
      rd_done_q  <= rd_done_d;
      rostb_q    <= rostb_d;
      to_q       <= to_d;
    end
  end

  assign VMEWrDone   = wr_req;
  assign VMERdDone   = rd_done_q;
  assign VMERdData   = rd_data_q;
  assign Rw_o        = rw_q;
  assign RwWStb_o    = wstb_q;
  assign RoRStb_o    = rostb_q;
  assign RdTimeout_o = to_q;
  assign rd_state_o  = rd_state_q;

endmodule

// File: tb/tb_sub_regbank_pipe.sv
// Bench for sub_regbank_pipe: directed and random bus traffic against a cycle-level
// transaction model, with a scoreboard monitor popping expected responses.
module tb_sub_regbank_pipe;

  localparam int          TO      = 15;
  localparam logic [31:0] RST_VAL = 32'h0000_1234;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // main instance: pipelined writes, handshaked read-only registers
  logic [3:1]  addr;
  logic [15:0] wr_data, rd_data;
  logic        rd_mem, wr_mem, rd_done, wr_done, rd_to;
  logic [31:0] rw_o, ro_i;
  logic [1:0]  wstb, rostb, ro_ack, st;

  // second instance: unpipelined writes, immediate read-only sampling
  logic [3:1]  addr0;
  logic [15:0] wr_data0, rd_data0;
  logic        rd_mem0, wr_mem0, rd_done0, wr_done0, rd_to0;
  logic [31:0] rw0, ro_i0;
  logic [1:0]  wstb0, rostb0, ro_ack0, st0;

  sub_regbank_pipe #(.RW_RST(RST_VAL), .WR_PIPE(1), .TIMEOUT(TO)) u_dut (
    .Clk(clk), .RstN(rst_n), .VMEAddr(addr), .VMERdData(rd_data), .VMEWrData(wr_data),
    .VMERdMem(rd_mem), .VMEWrMem(wr_mem), .VMERdDone(rd_done), .VMEWrDone(wr_done),
    .Rw_o(rw_o), .RwWStb_o(wstb), .Ro_i(ro_i), .RoRStb_o(rostb), .RoAck_i(ro_ack),
    .RdTimeout_o(rd_to), .rd_state_o(st));

  sub_regbank_pipe #(.RW_RST(RST_VAL), .WR_PIPE(0), .TIMEOUT(0)) u_dut0 (
    .Clk(clk), .RstN(rst_n), .VMEAddr(addr0), .VMERdData(rd_data0), .VMEWrData(wr_data0),
    .VMERdMem(rd_mem0), .VMEWrMem(wr_mem0), .VMERdDone(rd_done0), .VMEWrDone(wr_done0),
    .Rw_o(rw0), .RwWStb_o(wstb0), .Ro_i(ro_i0), .RoRStb_o(rostb0), .RoAck_i(ro_ack0),
    .RdTimeout_o(rd_to0), .rd_state_o(st0));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard queues: value plus the cycle in which it must appear
  logic [16:0] exp_q[$];      // {timeout, read data}
  int          exp_cyc_q[$];
  int          exp_wd_cyc_q[$];
  logic [33:0] exp_ws_q[$];   // {strobe mask, Rw_o}
  int          exp_ws_cyc_q[$];
  logic [1:0]  exp_rs_q[$];
  int          exp_rs_cyc_q[$];

  // reference model state
  logic [15:0] m_now[2];
  logic [15:0] m_com[2];
  int          wl_cyc[$];
  int          wl_idx[$];
  logic [15:0] wl_dat[$];
  bit          pend;
  int          pend_k, pend_ack, pend_end, rd_free;
  logic [15:0] pend_val;

  task automatic model_reset();
    exp_q.delete(); exp_cyc_q.delete(); exp_wd_cyc_q.delete();
    exp_ws_q.delete(); exp_ws_cyc_q.delete(); exp_rs_q.delete(); exp_rs_cyc_q.delete();
    wl_cyc.delete(); wl_idx.delete(); wl_dat.delete();
    m_now[0] = RST_VAL[15:0]; m_now[1] = RST_VAL[31:16];
    m_com[0] = RST_VAL[15:0]; m_com[1] = RST_VAL[31:16];
    pend = 0; rd_free = 0; pend_ack = -1;
  endtask

  // A read sees a write only once that write has committed on an earlier edge.
  task automatic model_read(input int ridx, input int ack_off, input logic [15:0] rval);
    int k;
    while (wl_cyc.size() > 0 && wl_cyc[0] <= cyc - 2) begin
      m_com[wl_idx[0]] = wl_dat[0];
      void'(wl_cyc.pop_front()); void'(wl_idx.pop_front()); void'(wl_dat.pop_front());
    end
    if (ridx < 2) begin
      exp_q.push_back({1'b0, m_com[ridx]}); exp_cyc_q.push_back(cyc + 1); rd_free = cyc + 1;
    end else if (ridx < 4) begin
      k = ridx - 2;
      exp_rs_q.push_back(2'(1 << k)); exp_rs_cyc_q.push_back(cyc + 1);
      pend = 1; pend_k = k; pend_end = cyc + TO; pend_val = rval;
      if (ack_off < TO) begin
        pend_ack = cyc + 1 + ack_off;
        exp_q.push_back({1'b0, rval}); exp_cyc_q.push_back(cyc + 3 + ack_off);
        rd_free = cyc + 3 + ack_off;
      end else begin
        pend_ack = -1;
        exp_q.push_back({1'b1, 16'hFFFF}); exp_cyc_q.push_back(cyc + 2 + TO);
        rd_free = cyc + 2 + TO;
      end
    end else begin
      exp_q.push_back(17'h0); exp_cyc_q.push_back(cyc + 1); rd_free = cyc + 1;
    end
  endtask

  // One bus cycle on the main instance; called just after a rising edge.
  task automatic step(input bit do_rd, input int ridx, input int ack_off, input logic [15:0] rval,
                      input bit do_wr, input int widx, input logic [15:0] wdata);
    logic [1:0] noise;
    rd_mem = 1'b0; wr_mem = 1'b0; ro_ack = '0;
    ro_i = {16'($urandom), 16'($urandom)};
    if (pend && cyc > pend_end) pend = 0;
    if (pend) begin
      noise = 2'($urandom);
      noise[pend_k] = 1'b0;
      ro_ack = noise;
      if (cyc == pend_ack) begin
        ro_ack[pend_k] = 1'b1;
        ro_i[pend_k*16 +: 16] = pend_val;
      end
    end
    if (do_wr) begin
      wr_mem = 1'b1; addr = 3'(widx); wr_data = wdata;
      exp_wd_cyc_q.push_back(cyc + 1);
      if (widx < 2) begin
        m_now[widx] = wdata;
        wl_cyc.push_back(cyc); wl_idx.push_back(widx); wl_dat.push_back(wdata);
        exp_ws_q.push_back({2'(1 << widx), m_now[1], m_now[0]});
        exp_ws_cyc_q.push_back(cyc + 2);
      end
    end
    if (do_rd) begin
      rd_mem = 1'b1; addr = 3'(ridx);
      if (cyc >= rd_free) model_read(ridx, ack_off, rval);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 0, 0, 16'h0);
  endtask

  task automatic wait_free();
    for (int i = 0; i < 100 && cyc < rd_free; i++) idle(1);
  endtask

  // monitor: pops and compares whenever the main instance presents an event
  logic [16:0] e_rd;
  logic [33:0] e_ws;
  logic [1:0]  e_rs;
  int          e_cyc;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_done) begin
        if (exp_q.size() == 0) check("rd_done_unexpected", rd_done, 1'b0);
        else begin
          e_rd = exp_q.pop_front(); e_cyc = exp_cyc_q.pop_front();
          check("rd_data", rd_data, e_rd[15:0]);
          check("rd_timeout", rd_to, e_rd[16]);
          check("rd_cycle", cyc, e_cyc);
        end
      end else if (rd_to) check("rd_timeout_stray", rd_to, 1'b0);
      if (wr_done) begin
        if (exp_wd_cyc_q.size() == 0) check("wr_done_unexpected", wr_done, 1'b0);
        else check("wr_done_cycle", cyc, exp_wd_cyc_q.pop_front());
      end
      if (wstb != 2'b00) begin
        if (exp_ws_q.size() == 0) check("wstb_unexpected", wstb, 2'b00);
        else begin
          e_ws = exp_ws_q.pop_front(); e_cyc = exp_ws_cyc_q.pop_front();
          check("wstb_mask", wstb, e_ws[33:32]);
          check("wstb_rw", rw_o, e_ws[31:0]);
          check("wstb_cycle", cyc, e_cyc);
        end
      end
      if (rostb != 2'b00) begin
        if (exp_rs_q.size() == 0) check("rostb_unexpected", rostb, 2'b00);
        else begin
          e_rs = exp_rs_q.pop_front(); e_cyc = exp_rs_cyc_q.pop_front();
          check("rostb_mask", rostb, e_rs);
          check("rostb_cycle", cyc, e_cyc);
        end
      end
    end
  end

  initial begin
    bit dr, dw;
    int ri, wi, ao;
    n_cmp = 0; n_fail = 0;
    model_reset();
    rst_n = 1'b0;
    addr = '0; wr_data = '0; rd_mem = 1'b0; wr_mem = 1'b0; ro_i = '0; ro_ack = '0;
    addr0 = '0; wr_data0 = '0; rd_mem0 = 1'b0; wr_mem0 = 1'b0; ro_i0 = '0; ro_ack0 = '0;

    // clock/reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rw", rw_o, RST_VAL);
    check("rst_rd_data", rd_data, 16'h0);
    check("rst_outs", {rd_done, wr_done, wstb, rostb, rd_to}, 7'h0);
    check("rst_rw_p0", rw0, RST_VAL);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_rw_slice0", rw_o[15:0], 16'h1234);
    check("rel_rw_slice1", rw_o[31:16], 16'h0000);
    check("rel_outs", {rd_done, wr_done, wstb, rostb, rd_to}, 7'h0);
    @(posedge clk); #1;

    // unpipelined instance: write acknowledged and committed one edge earlier
    wr_mem0 = 1'b1; addr0 = 3'd1; wr_data0 = 16'hBEEF;
    @(negedge clk);
    check("p0_wr_done", wr_done0, 1'b1);
    check("p0_rw_before", rw0[31:16], 16'h0000);
    @(posedge clk); #1 wr_mem0 = 1'b0;
    @(negedge clk);
    check("p0_rw_after", rw0, 32'hBEEF_1234);
    check("p0_wstb", wstb0, 2'b10);
    check("p0_wr_done_off", wr_done0, 1'b0);
    @(posedge clk); #1 rd_mem0 = 1'b1; addr0 = 3'd2; ro_i0 = 32'h1111_C3C3;
    @(negedge clk);
    check("p0_wstb_off", wstb0, 2'b00);
    @(posedge clk); #1 addr0 = 3'd3; ro_i0 = 32'h7E7E_0000;
    @(negedge clk);
    check("p0_ro0_done", rd_done0, 1'b1);
    check("p0_ro0_data", rd_data0, 16'hC3C3);
    check("p0_rostb", rostb0, 2'b00);
    @(posedge clk); #1 addr0 = 3'd7;
    @(negedge clk);
    check("p0_ro1_data", rd_data0, 16'h7E7E);
    @(posedge clk); #1 rd_mem0 = 1'b0;
    @(negedge clk);
    check("p0_unmapped", {rd_done0, rd_data0}, {1'b1, 16'h0});
    @(posedge clk); #1;
    @(negedge clk);
    check("p0_done_off", rd_done0, 1'b0);
    @(posedge clk); #1;

    // main instance directed cases
    step(0, 0, 0, 16'h0, 1, 1, 16'hBEEF); idle(3);
    step(1, 2, 3, 16'hA5A5, 0, 0, 16'h0); wait_free(); idle(1);
    step(1, 3, TO, 16'h0, 0, 0, 16'h0); wait_free();
    step(1, 0, 0, 16'h0, 0, 0, 16'h0); idle(2);
    step(1, 2, TO - 1, 16'h5A5A, 0, 0, 16'h0); wait_free();
    step(1, 7, 0, 16'h0, 0, 0, 16'h0); idle(1);
    step(0, 0, 0, 16'h0, 1, 2, 16'h1111); idle(3);
    step(1, 1, 0, 16'h0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 1, 0, 16'hCAFE);
    step(1, 0, 0, 16'h0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 0, 0, 16'h0); idle(3);

    // random traffic, including reads dropped while the FSM is busy
    for (int i = 0; i < 700; i++) begin
      dr = ($urandom_range(0, 2) == 0);
      dw = ($urandom_range(0, 3) == 0);
      ri = $urandom_range(0, 7);
      wi = $urandom_range(0, 7);
      if (dr && dw) wi = ri;
      case ($urandom_range(0, 5))
        0:       ao = TO - 1;
        1:       ao = TO;
        default: ao = $urandom_range(0, TO - 1);
      endcase
      step(dr, ri, ao, 16'($urandom), dw, wi, 16'($urandom));
    end
    wait_free(); idle(4);

    // reset while waiting on a read-only acknowledge
    step(0, 0, 0, 16'h0, 1, 1, 16'h4242); idle(3);
    step(1, 3, TO, 16'h0, 0, 0, 16'h0); idle(5);
    rd_mem = 1'b0; wr_mem = 1'b0; ro_ack = '0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {rd_done, wr_done, wstb, rostb, rd_to}, 7'h0);
    check("mid_rst_rd_data", rd_data, 16'h0);
    check("mid_rst_rw", rw_o, RST_VAL);
    model_reset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    idle(TO + 10);
    step(1, 0, 0, 16'h0, 0, 0, 16'h0);
    step(1, 3, 2, 16'h6C6C, 0, 0, 16'h0); wait_free(); idle(4);

    // final report
    check("left_rd", exp_q.size(), 0);
    check("left_wr_done", exp_wd_cyc_q.size(), 0);
    check("left_wstb", exp_ws_q.size(), 0);
    check("left_rostb", exp_rs_q.size(), 0);
    check("final_rw", rw_o, {m_now[1], m_now[0]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
